// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NR, computing each next key on the fly.
// Latency: round 0 valid one cycle after an accepted start; then one key per accepted beat.
// Backpressure: round_key/round_idx/rk_valid hold stable while rk_ready is low.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_e;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  // FIPS-197 forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           done_q, done_d;

  logic [31:0]    w0, w1, w2, w3, rot_w3, t_word, n0, n1, n2, n3;

  always_comb begin
    w0     = key_q[127:96];
    w1     = key_q[95:64];
    w2     = key_q[63:32];
    w3     = key_q[31:0];
    rot_w3 = {w3[23:0], w3[31:24]};
    t_word = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
              sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ {rcon_q, 24'h0};
    n0     = w0 ^ t_word;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          // Last key leaves round_key/round_idx in place for the consumer.
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d  = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized bench for aes_key_expand: GF(2^8)-derived S-box and word-level key expansion model.
module tb_aes_key_expand;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic [127:0] key_in;
  logic         rk_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;

  logic         start2, rk_ready2;
  logic [127:0] key_in2;
  logic         rk_valid2, busy2, done2;
  logic [127:0] round_key2;
  logic [3:0]   round_idx2;

  int tests = 0;
  int fails = 0;

  aes_key_expand #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .round_key(round_key), .round_idx(round_idx),
    .busy(busy), .done(done));

  aes_key_expand #(.NR(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .key_in(key_in2), .rk_ready(rk_ready2),
    .rk_valid(rk_valid2), .round_key(round_key2), .round_idx(round_idx2),
    .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box derived from GF(2^8) multiplicative inverse plus the affine transform.
  logic [7:0] sb [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [7:0]  rc [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 4*r + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Transaction-level expectation of the NR=10 instance.
  logic         m_have, m_active, m_done;
  int           m_r;
  logic [127:0] m_key0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have   <= 1'b0;
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_r      <= 0;
      m_key0   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (rk_ready) begin
          if (m_r == 10) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
          end else begin
            m_r <= m_r + 1;
          end
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_have   <= 1'b1;
        m_r      <= 0;
        m_key0   <= key_in;
      end
    end
  end

  always @(negedge clk) begin
    chk("rk_valid",  128'(rk_valid),  128'(m_active));
    chk("busy",      128'(busy),      128'(m_active));
    chk("done",      128'(done),      128'(m_done));
    chk("round_idx", 128'(round_idx), 128'(m_r));
    chk("round_key", round_key, m_have ? rk_of(m_key0, m_r) : 128'h0);
  end

  // inject: 0 none, 1 extra start at round 3, 2 async reset at round 5.
  task automatic run_key(input logic [127:0] k, input bit rand_ready, input int inject);
    int           beats = 0;
    int           vcyc = 0;
    bit           fin = 1'b0;
    bit           stalled = 1'b0;
    logic [127:0] prev = '0;
    logic [3:0]   prev_idx = '0;
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 300 && !fin; c++) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        if (stalled) begin
          chk("stall_key", round_key, prev);
          chk("stall_idx", 128'(round_idx), 128'(prev_idx));
        end
        if (rk_valid) vcyc++;
        if (inject == 2 && rk_valid && round_idx == 4'd5) begin
          #2 rst_n = 1'b0;
          #1;
          chk("arst_valid", 128'(rk_valid), 128'(0));
          chk("arst_busy",  128'(busy),     128'(0));
          chk("arst_key",   round_key,      128'h0);
          chk("arst_idx",   128'(round_idx), 128'(0));
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (inject == 1 && rk_valid && round_idx == 4'd3) begin
          start  = 1'b1;
          key_in = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          start = 1'b0;
        end
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rk_valid && rk_ready) beats++;
        stalled  = rk_valid && !rk_ready;
        prev     = round_key;
        prev_idx = round_idx;
        @(negedge clk);
      end
    end
    chk("done_seen", 128'(fin), 128'(1));
    chk("beats", 128'(beats), 128'(11));
    if (!rand_ready) chk("valid_cycles", 128'(vcyc), 128'(11));
    if (inject == 0) chk("final_key", round_key, rk_of(k, 10));
  endtask

  initial begin
    logic [127:0] lit2 [0:2];
    lit2[0] = FIPS_KEY;
    lit2[1] = FIPS_R1;
    lit2[2] = FIPS_R2;

    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    start2 = 1'b0; rk_ready2 = 1'b1; key_in2 = '0;
    build_sbox();

    chk("model_sb00",  128'(sb[8'h00]), 128'h63);
    chk("model_sb53",  128'(sb[8'h53]), 128'hed);
    chk("model_fips1", rk_of(FIPS_KEY, 1),  FIPS_R1);
    chk("model_fips2", rk_of(FIPS_KEY, 2),  FIPS_R2);
    chk("model_fips10", rk_of(FIPS_KEY, 10), FIPS_R10);
    chk("model_zero1", rk_of(128'h0, 1),  ZERO_R1);
    chk("model_zero10", rk_of(128'h0, 10), ZERO_R10);

    #3;
    chk("rst_valid", 128'(rk_valid),  128'(0));
    chk("rst_busy",  128'(busy),      128'(0));
    chk("rst_done",  128'(done),      128'(0));
    chk("rst_key",   round_key,       128'h0);
    chk("rst_idx",   128'(round_idx), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_key(FIPS_KEY, 1'b0, 0);
    chk("fips_r10", round_key, FIPS_R10);
    run_key(FIPS_KEY, 1'b1, 0);
    run_key(128'h0, 1'b0, 0);
    chk("zero_r10", round_key, ZERO_R10);
    run_key(FIPS_KEY, 1'b1, 1);
    chk("restart_ignored_r10", round_key, FIPS_R10);
    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2);
    for (int n = 0; n < 6; n++)
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    start2  = 1'b1;
    key_in2 = FIPS_KEY;
    @(negedge clk);
    start2  = 1'b0;
    key_in2 = '0;
    for (int r = 0; r < 3; r++) begin
      chk("nr2_valid", 128'(rk_valid2),  128'(1));
      chk("nr2_idx",   128'(round_idx2), 128'(r));
      chk("nr2_key",   round_key2,       lit2[r]);
      @(negedge clk);
    end
    chk("nr2_done",       128'(done2),      128'(1));
    chk("nr2_busy_after", 128'(busy2),      128'(0));
    chk("nr2_valid_after", 128'(rk_valid2), 128'(0));
    chk("nr2_idx_hold",   128'(round_idx2), 128'(2));
    chk("nr2_key_hold",   round_key2,       FIPS_R2);
    @(negedge clk);
    chk("nr2_done_pulse", 128'(done2), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
